code_lock: RTL and testbench
============================

Name: code_lock

Overview:
- Parametrised keypad lock controller; successor to the single-bit open/close lock FSM.
- Accepts a CODE_LEN-digit code, compares it against a programmable code, and sequences timed OPENING/CLOSING transitions.
- Adds failed-attempt counting with timed lockout, and a partial-entry timeout.
- Sits behind the keypad front end; drives the actuator/status logic.

Parameters:
DIGIT_WIDTH, 4, bits per entered digit (>=1)
CODE_LEN, 4, digits per code (>=1)
OPEN_CYCLES, 3, cycles spent in STATE_OPENING (>=1)
CLOSE_CYCLES, 2, cycles spent in STATE_CLOSING (>=1)
MAX_FAILS, 3, consecutive wrong codes that trigger lockout (>=1)
LOCKOUT_CYCLES, 16, cycles spent in STATE_LOCKOUT (>=1)
ENTRY_TIMEOUT, 8, idle cycles after which a partial entry is discarded (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
digit_valid  in  1  digit strobe, one digit per asserted cycle
digit  in  DIGIT_WIDTH  digit value, sampled when digit_valid=1
code  in  CODE_LEN*DIGIT_WIDTH  programmed code; digit i = code[i*DIGIT_WIDTH +: DIGIT_WIDTH], i=0 entered first
close  in  1  close request
state  out  lock_pkg::state  current FSM state
opened  out  1  state==STATE_OPENED
locked_out  out  1  state==STATE_LOCKOUT
entry_count  out  $clog2(CODE_LEN+1)  digits accepted in current entry
fail_count  out  $clog2(MAX_FAILS+1)  consecutive failed attempts

Behaviour:
- Reset: synchronous, active-high; rst wins over every other input, including mid-timer and mid-entry. Reset values: state=STATE_CLOSED, entry_count=0, fail_count=0, entry buffer=0, all timers=0.
- All outputs are registered or decoded from registered state; a change caused by an input sampled at edge N is visible after edge N.
- STATE_CLOSED, digit_valid=1, entry_count<CODE_LEN-1:
  - store digit at index entry_count; entry_count++.
  - reload idle timer to ENTRY_TIMEOUT-1.
- STATE_CLOSED, digit_valid=1, entry_count==CODE_LEN-1 (final digit):
  - compare the full entry, including this digit, against code in the same cycle.
  - entry_count->0.
  - Match: state->STATE_OPENING, fail_count->0, phase timer loads OPEN_CYCLES-1.
  - Mismatch, fail_count+1<MAX_FAILS: fail_count++, state stays CLOSED.
  - Mismatch, fail_count+1==MAX_FAILS: state->STATE_LOCKOUT, phase timer loads LOCKOUT_CYCLES-1, fail_count saturates at MAX_FAILS.
- Entry timeout: in CLOSED with 0<entry_count, ENTRY_TIMEOUT consecutive cycles without digit_valid clear entry_count to 0.
  - A timeout is not a failure.
  - If a digit arrives in the expiry cycle, the digit wins: it is accepted and the timer reloads.
- code is sampled only at the compare cycle; changing code mid-entry affects only that compare.
- STATE_OPENING:
  - held exactly OPEN_CYCLES cycles (phase timer decrements; at 0 -> STATE_OPENED).
  - close and digits are ignored.
- STATE_OPENED: close=1 -> STATE_CLOSING, phase timer loads CLOSE_CYCLES-1. Digits are ignored.
- STATE_CLOSING: held exactly CLOSE_CYCLES cycles, then -> STATE_CLOSED. Inputs are ignored.
- STATE_LOCKOUT: held exactly LOCKOUT_CYCLES cycles, then -> STATE_CLOSED with fail_count->0. Inputs are ignored.
- Digits outside CLOSED are dropped and do not touch entry_count.
- entry_count is always 0 outside CLOSED.
- close in CLOSED is ignored.

Decomposition:
- lock_pkg holds:
  - enum state: STATE_CLOSED, STATE_OPENING, STATE_OPENED, STATE_CLOSING, STATE_LOCKOUT.
  - shared timing defaults as localparams.
- One sub-module, lock_timer: parametrised down-counter with load/value/expired.
  - one instance serves as the phase timer (OPENING/CLOSING/LOCKOUT share it; only one is active at a time).
  - one instance serves as the entry idle timer.

Test Plan:
- Defaults, code=16'h4321; digits 1,2,3,4 on consecutive cycles -> state OPENING 3 cycles, then OPENED; fail_count=0; close=1 -> CLOSING 2 cycles, then CLOSED.
- Digits 1,2,3,5 -> stays CLOSED, fail_count=1, entry_count=0; repeat twice more -> STATE_LOCKOUT for exactly 16 cycles, digits 1,2,3,4 during lockout ignored; then CLOSED with fail_count=0.
- Two wrong codes (fail_count=2), then correct code -> OPENING and fail_count=0.
- Digits 1,2, then 8 idle cycles -> entry_count=0, fail_count unchanged; digits 1,2,3,4 then opens. Digit on the 8th idle cycle -> entry_count=3, not cleared.
- rst asserted during OPENING, mid-entry (entry_count=2), and during LOCKOUT -> next cycle all outputs at reset values.
- CODE_LEN=1, DIGIT_WIDTH=8, OPEN_CYCLES=1, code=8'hA5: digit 8'hA5 -> OPENING 1 cycle, then OPENED; close held through OPENING has no effect until OPENED.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared types and timing defaults for the keypad code lock.
package lock_pkg;

    typedef enum logic [2:0] {
        STATE_CLOSED,
        STATE_OPENING,
        STATE_OPENED,
        STATE_CLOSING,
        STATE_LOCKOUT
    } state;

    localparam int DEF_DIGIT_WIDTH    = 4;
    localparam int DEF_CODE_LEN       = 4;
    localparam int DEF_OPEN_CYCLES    = 3;
    localparam int DEF_CLOSE_CYCLES   = 2;
    localparam int DEF_MAX_FAILS      = 3;
    localparam int DEF_LOCKOUT_CYCLES = 16;
    localparam int DEF_ENTRY_TIMEOUT  = 8;

    // Width of a down-counter holding values 0..n-1, never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/code_lock_if.sv
// Keypad-side inputs and status outputs of the code lock, bundled as one port.
interface code_lock_if #(
    parameter int DIGIT_WIDTH = lock_pkg::DEF_DIGIT_WIDTH,
    parameter int CODE_LEN    = lock_pkg::DEF_CODE_LEN,
    parameter int MAX_FAILS   = lock_pkg::DEF_MAX_FAILS
);
    localparam int ENTRY_W = $clog2(CODE_LEN + 1);
    localparam int FAIL_W  = $clog2(MAX_FAILS + 1);

    logic                            digit_valid_i;
    logic [DIGIT_WIDTH-1:0]          digit_i;
    logic [CODE_LEN*DIGIT_WIDTH-1:0] code_i;
    logic                            close_i;
    lock_pkg::state                  state_o;
    logic                            opened_o;
    logic                            locked_out_o;
    logic [ENTRY_W-1:0]              entry_count_o;
    logic [FAIL_W-1:0]               fail_count_o;

    modport master (
        output digit_valid_i, digit_i, code_i, close_i,
        input  state_o, opened_o, locked_out_o, entry_count_o, fail_count_o
    );

    modport slave (
        input  digit_valid_i, digit_i, code_i, close_i,
        output state_o, opened_o, locked_out_o, entry_count_o, fail_count_o
    );
endinterface

// File: rtl/lock_timer.sv
// Loadable down-counter that stops at zero; expired_o flags the zero value.
module lock_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             expired_o
);
    logic [WIDTH-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (dec_i && value_q != '0) begin
            value_d = value_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign expired_o = (value_q == '0);
endmodule

// File: rtl/code_lock.sv
// Keypad code lock: digit entry and compare, timed open/close sequencing,
// failed-attempt lockout and partial-entry timeout.
module code_lock
    import lock_pkg::*;
#(
    parameter int DIGIT_WIDTH    = DEF_DIGIT_WIDTH,
    parameter int CODE_LEN       = DEF_CODE_LEN,
    parameter int OPEN_CYCLES    = DEF_OPEN_CYCLES,
    parameter int CLOSE_CYCLES   = DEF_CLOSE_CYCLES,
    parameter int MAX_FAILS      = DEF_MAX_FAILS,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int ENTRY_TIMEOUT  = DEF_ENTRY_TIMEOUT
) (
    input logic        clk,
    input logic        rst,
    code_lock_if.slave bus
);
    localparam int ENTRY_W   = $clog2(CODE_LEN + 1);
    localparam int FAIL_W    = $clog2(MAX_FAILS + 1);
    localparam int CODE_W    = CODE_LEN * DIGIT_WIDTH;
    localparam int PHASE_MAX = (OPEN_CYCLES > CLOSE_CYCLES)
                             ? ((OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES)
                             : ((CLOSE_CYCLES > LOCKOUT_CYCLES) ? CLOSE_CYCLES : LOCKOUT_CYCLES);
    localparam int PHASE_W   = cnt_width(PHASE_MAX);
    localparam int IDLE_W    = cnt_width(ENTRY_TIMEOUT);
    localparam logic [ENTRY_W-1:0] LAST_IDX = ENTRY_W'(CODE_LEN - 1);

    state               state_q, state_d;
    logic [ENTRY_W-1:0] entry_count_q, entry_count_d;
    logic [FAIL_W-1:0]  fail_count_q, fail_count_d;
    logic [CODE_W-1:0]  entry_q, entry_d;
    logic [CODE_W-1:0]  candidate;

    logic               phase_load, phase_dec, phase_expired;
    logic [PHASE_W-1:0] phase_load_val;
    logic               idle_load, idle_dec, idle_expired;

    // Shared by OPENING, CLOSING and LOCKOUT: only one phase runs at a time.
    lock_timer #(.WIDTH(PHASE_W)) u_phase_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (phase_load),
        .load_val_i (phase_load_val),
        .dec_i      (phase_dec),
        .expired_o  (phase_expired)
    );

    lock_timer #(.WIDTH(IDLE_W)) u_idle_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (idle_load),
        .load_val_i (IDLE_W'(ENTRY_TIMEOUT - 1)),
        .dec_i      (idle_dec),
        .expired_o  (idle_expired)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d        = state_q;
        entry_count_d  = entry_count_q;
        fail_count_d   = fail_count_q;
        entry_d        = entry_q;
        candidate      = entry_q;
        phase_load     = 1'b0;
        phase_load_val = '0;
        phase_dec      = 1'b0;
        idle_load      = 1'b0;
        idle_dec       = 1'b0;

        case (state_q)
            STATE_CLOSED: begin
                if (bus.digit_valid_i) begin
                    if (entry_count_q == LAST_IDX) begin
                        // The final digit joins the compare in the same cycle it arrives.
                        candidate[int'(LAST_IDX)*DIGIT_WIDTH +: DIGIT_WIDTH] = bus.digit_i;
                        entry_count_d = '0;
                        if (candidate == bus.code_i) begin
                            state_d        = STATE_OPENING;
                            fail_count_d   = '0;
                            phase_load     = 1'b1;
                            phase_load_val = PHASE_W'(OPEN_CYCLES - 1);
                        end else if (int'(fail_count_q) + 1 < MAX_FAILS) begin
                            fail_count_d = fail_count_q + 1'b1;
                        end else begin
                            state_d        = STATE_LOCKOUT;
                            fail_count_d   = FAIL_W'(MAX_FAILS);
                            phase_load     = 1'b1;
                            phase_load_val = PHASE_W'(LOCKOUT_CYCLES - 1);
                        end
                    end else begin
                        entry_d[int'(entry_count_q)*DIGIT_WIDTH +: DIGIT_WIDTH] = bus.digit_i;
                        entry_count_d = entry_count_q + 1'b1;
                        idle_load     = 1'b1;
                    end
                end else if (entry_count_q != '0) begin
                    if (idle_expired) begin
                        entry_count_d = '0;
                    end else begin
                        idle_dec = 1'b1;
                    end
                end
            end

            STATE_OPENING: begin
                if (phase_expired) state_d = STATE_OPENED;
                else               phase_dec = 1'b1;
            end

            STATE_OPENED: begin
                if (bus.close_i) begin
                    state_d        = STATE_CLOSING;
                    phase_load     = 1'b1;
                    phase_load_val = PHASE_W'(CLOSE_CYCLES - 1);
                end
            end

            STATE_CLOSING: begin
                if (phase_expired) state_d = STATE_CLOSED;
                else               phase_dec = 1'b1;
            end

            STATE_LOCKOUT: begin
                if (phase_expired) begin
                    state_d      = STATE_CLOSED;
                    fail_count_d = '0;
                end else begin
                    phase_dec = 1'b1;
                end
            end

            default: state_d = STATE_CLOSED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= STATE_CLOSED;
            entry_count_q <= '0;
            fail_count_q  <= '0;
            // NOTE: the entry buffer is a plain register, so clearing it on reset is cheap and keeps stale digits from surviving a reset.
            entry_q       <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all updates land together at the edge.
            state_q       <= state_d;
            entry_count_q <= entry_count_d;
            fail_count_q  <= fail_count_d;
            entry_q       <= entry_d;
        end
    end

    assign bus.state_o       = state_q;
    assign bus.opened_o      = (state_q == STATE_OPENED);
    assign bus.locked_out_o  = (state_q == STATE_LOCKOUT);
    assign bus.entry_count_o = entry_count_q;
    assign bus.fail_count_o  = fail_count_q;
endmodule

// File: tb/tb_code_lock.sv
// Directed bench for code_lock: default build plus a one-digit, 8-bit build.
module tb_code_lock;
    import lock_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    code_lock_if                                          bus0 ();
    code_lock_if #(.DIGIT_WIDTH(8), .CODE_LEN(1))         bus1 ();

    code_lock u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    code_lock #(.DIGIT_WIDTH(8), .CODE_LEN(1), .OPEN_CYCLES(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic digit0(input logic [3:0] d);
        bus0.digit_valid_i = 1'b1;
        bus0.digit_i       = d;
        tick();
        bus0.digit_valid_i = 1'b0;
    endtask

    task automatic enter0(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
        digit0(a);
        digit0(b);
        digit0(c);
        digit0(d);
    endtask

    // From the first OPENING cycle of the default build back to CLOSED.
    task automatic finish_open_close(input string tag);
        tick_n(3);
        check({tag, "_opened"}, bus0.state_o, STATE_OPENED);
        bus0.close_i = 1'b1;
        tick();
        bus0.close_i = 1'b0;
        check({tag, "_closing"}, bus0.state_o, STATE_CLOSING);
        tick_n(2);
        check({tag, "_closed"}, bus0.state_o, STATE_CLOSED);
    endtask

    initial begin
        rst                = 1'b1;
        bus0.digit_valid_i = 1'b0;
        bus0.digit_i       = '0;
        bus0.code_i        = 16'h4321;
        bus0.close_i       = 1'b0;
        bus1.digit_valid_i = 1'b0;
        bus1.digit_i       = '0;
        bus1.code_i        = 8'hA5;
        bus1.close_i       = 1'b0;
        tick_n(2);
        rst = 1'b0;

        // Reset state
        check("rst_state", bus0.state_o, STATE_CLOSED);
        check("rst_entry", bus0.entry_count_o, 0);
        check("rst_fail", bus0.fail_count_o, 0);
        check("rst_opened", bus0.opened_o, 0);
        check("rst_locked", bus0.locked_out_o, 0);

        // Correct code opens, OPENING lasts 3 cycles, CLOSING 2
        digit0(4'd1);
        check("entry1", bus0.entry_count_o, 1);
        digit0(4'd2);
        digit0(4'd3);
        check("entry3", bus0.entry_count_o, 3);
        digit0(4'd4);
        check("open_c1", bus0.state_o, STATE_OPENING);
        check("open_entry0", bus0.entry_count_o, 0);
        tick();
        check("open_c2", bus0.state_o, STATE_OPENING);
        tick();
        check("open_c3", bus0.state_o, STATE_OPENING);
        tick();
        check("opened", bus0.state_o, STATE_OPENED);
        check("opened_flag", bus0.opened_o, 1);
        check("opened_fail", bus0.fail_count_o, 0);
        digit0(4'd1);
        check("opened_digit_ignored", bus0.entry_count_o, 0);
        bus0.close_i = 1'b1;
        tick();
        bus0.close_i = 1'b0;
        check("closing_c1", bus0.state_o, STATE_CLOSING);
        tick();
        check("closing_c2", bus0.state_o, STATE_CLOSING);
        tick();
        check("closed_after", bus0.state_o, STATE_CLOSED);
        bus0.close_i = 1'b1;
        tick();
        bus0.close_i = 1'b0;
        check("close_in_closed", bus0.state_o, STATE_CLOSED);

        // Three wrong codes -> 16-cycle lockout
        enter0(4'd1, 4'd2, 4'd3, 4'd5);
        check("wrong1_state", bus0.state_o, STATE_CLOSED);
        check("wrong1_fail", bus0.fail_count_o, 1);
        check("wrong1_entry", bus0.entry_count_o, 0);
        enter0(4'd1, 4'd2, 4'd3, 4'd5);
        check("wrong2_fail", bus0.fail_count_o, 2);
        enter0(4'd1, 4'd2, 4'd3, 4'd5);
        check("lock_c1", bus0.state_o, STATE_LOCKOUT);
        check("lock_flag", bus0.locked_out_o, 1);
        check("lock_fail_sat", bus0.fail_count_o, 3);
        enter0(4'd1, 4'd2, 4'd3, 4'd4);
        check("lock_c5", bus0.state_o, STATE_LOCKOUT);
        check("lock_entry0", bus0.entry_count_o, 0);
        tick_n(11);
        check("lock_c16", bus0.state_o, STATE_LOCKOUT);
        tick();
        check("lock_done", bus0.state_o, STATE_CLOSED);
        check("lock_done_fail", bus0.fail_count_o, 0);

        // Two failures then correct code clears fail_count
        enter0(4'd1, 4'd2, 4'd3, 4'd5);
        enter0(4'd9, 4'd9, 4'd9, 4'd9);
        check("pre_ok_fail", bus0.fail_count_o, 2);
        enter0(4'd1, 4'd2, 4'd3, 4'd4);
        check("ok_after_fails", bus0.state_o, STATE_OPENING);
        check("ok_fail_cleared", bus0.fail_count_o, 0);
        digit0(4'd1);
        check("opening_digit_ignored", bus0.entry_count_o, 0);
        tick_n(1);
        check("opening_c3_after_digit", bus0.state_o, STATE_OPENING);
        tick();
        check("opened_after_digit", bus0.state_o, STATE_OPENED);
        bus0.close_i = 1'b1;
        tick();
        bus0.close_i = 1'b0;
        tick_n(2);
        check("closed_again", bus0.state_o, STATE_CLOSED);

        // Partial-entry timeout is not a failure
        enter0(4'd7, 4'd7, 4'd7, 4'd7);
        check("to_fail1", bus0.fail_count_o, 1);
        digit0(4'd1);
        digit0(4'd2);
        tick_n(7);
        check("to_idle7", bus0.entry_count_o, 2);
        tick();
        check("to_idle8", bus0.entry_count_o, 0);
        check("to_fail_kept", bus0.fail_count_o, 1);
        enter0(4'd1, 4'd2, 4'd3, 4'd4);
        check("to_then_open", bus0.state_o, STATE_OPENING);
        finish_open_close("to");

        // Digit in the expiry cycle wins
        digit0(4'd1);
        digit0(4'd2);
        tick_n(7);
        digit0(4'd3);
        check("expiry_digit_wins", bus0.entry_count_o, 3);
        digit0(4'd4);
        check("expiry_then_open", bus0.state_o, STATE_OPENING);
        finish_open_close("exp");

        // Code sampled only at the compare cycle
        digit0(4'd1);
        digit0(4'd2);
        digit0(4'd3);
        bus0.code_i = 16'h5321;
        digit0(4'd5);
        check("code_late_change", bus0.state_o, STATE_OPENING);
        bus0.code_i = 16'h4321;

        // Reset during OPENING
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_opening_state", bus0.state_o, STATE_CLOSED);
        check("rst_opening_opened", bus0.opened_o, 0);

        // Reset mid-entry with a pending failure
        enter0(4'd8, 4'd8, 4'd8, 4'd8);
        digit0(4'd1);
        digit0(4'd2);
        check("pre_rst_entry", bus0.entry_count_o, 2);
        check("pre_rst_fail", bus0.fail_count_o, 1);
        rst = 1'b1;
        bus0.digit_valid_i = 1'b1;
        bus0.digit_i       = 4'd3;
        tick();
        rst = 1'b0;
        bus0.digit_valid_i = 1'b0;
        check("rst_entry_entry", bus0.entry_count_o, 0);
        check("rst_entry_fail", bus0.fail_count_o, 0);
        check("rst_entry_state", bus0.state_o, STATE_CLOSED);

        // Reset during LOCKOUT
        enter0(4'd0, 4'd0, 4'd0, 4'd0);
        enter0(4'd0, 4'd0, 4'd0, 4'd0);
        enter0(4'd0, 4'd0, 4'd0, 4'd0);
        tick_n(3);
        check("pre_rst_lock", bus0.state_o, STATE_LOCKOUT);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_lock_state", bus0.state_o, STATE_CLOSED);
        check("rst_lock_flag", bus0.locked_out_o, 0);
        check("rst_lock_fail", bus0.fail_count_o, 0);
        enter0(4'd1, 4'd2, 4'd3, 4'd4);
        check("post_rst_open", bus0.state_o, STATE_OPENING);

        // One-digit build: OPEN_CYCLES=1, close held through OPENING
        check("d1_rst_state", bus1.state_o, STATE_CLOSED);
        bus1.digit_valid_i = 1'b1;
        bus1.digit_i       = 8'h5A;
        tick();
        check("d1_wrong_state", bus1.state_o, STATE_CLOSED);
        check("d1_wrong_fail", bus1.fail_count_o, 1);
        check("d1_wrong_entry", bus1.entry_count_o, 0);
        bus1.digit_i = 8'hA5;
        bus1.close_i = 1'b1;
        tick();
        bus1.digit_valid_i = 1'b0;
        check("d1_opening", bus1.state_o, STATE_OPENING);
        check("d1_fail_clear", bus1.fail_count_o, 0);
        tick();
        check("d1_opened", bus1.state_o, STATE_OPENED);
        check("d1_opened_flag", bus1.opened_o, 1);
        tick();
        bus1.close_i = 1'b0;
        check("d1_closing", bus1.state_o, STATE_CLOSING);
        tick_n(2);
        check("d1_closed", bus1.state_o, STATE_CLOSED);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
